// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with shadow/active digit banks and frame-aligned commit.
// Latency: seg_n/an_n registered and aligned to the slot position; commit_ack is combinational in the boundary cycle.
// Backpressure: none; writes always accepted, commits wait for the next frame boundary. Option: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 16
) (
    input  logic                  slow_clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  wr_on,
    input  logic                  commit_req,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  commit_ack,
    output logic                  frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = $clog2(REFRESH_DIV);

    typedef struct packed {
        logic       on;
        logic       dp;
        logic [3:0] val;
    } digit_t;

    digit_t          shadow_q   [NUM_DIGITS];
    digit_t          active_q   [NUM_DIGITS];
    digit_t          active_nxt [NUM_DIGITS];
    logic [DW-1:0]   div_q, div_nxt;
    logic [IW-1:0]   idx_q, idx_nxt;
    logic            run_q;
    logic            pending_q;
    logic            boundary;
    logic            commit_go;
    logic            wr_hit;
    logic [NUM_DIGITS-1:0] show;
    digit_t          cur;
    logic [7:0]      seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    function automatic logic [6:0] font7(input logic [3:0] v);
        case (v)
            4'h0: font7 = 7'h40;
            4'h1: font7 = 7'h79;
            4'h2: font7 = 7'h24;
            4'h3: font7 = 7'h30;
            4'h4: font7 = 7'h19;
            4'h5: font7 = 7'h12;
            4'h6: font7 = 7'h02;
            4'h7: font7 = 7'h78;
            4'h8: font7 = 7'h00;
            4'h9: font7 = 7'h10;
            4'hA: font7 = 7'h08;
            4'hB: font7 = 7'h03;
            4'hC: font7 = 7'h46;
            4'hD: font7 = 7'h21;
            4'hE: font7 = 7'h06;
            default: font7 = 7'h0E;
        endcase
    endfunction

    assign boundary   = run_q && (div_q == '0) && (idx_q == '0);
    assign commit_go  = boundary && (pending_q || commit_req);
    assign commit_ack = commit_go;
    assign wr_hit     = wr_en && ({29'd0, wr_addr} < 32'(NUM_DIGITS));

    // Counters sit at slot 0 of digit 0 for the first running cycle, so that cycle is a frame start.
    always_comb begin
        div_nxt = div_q;
        idx_nxt = idx_q;
        if (!run_q) begin
            div_nxt = '0;
            idx_nxt = '0;
        end else if (div_q == DW'(REFRESH_DIV - 1)) begin
            div_nxt = '0;
            idx_nxt = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            div_nxt = div_q + DW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            active_nxt[i] = commit_go ? shadow_q[i] : active_q[i];
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Scan from the most significant digit; zeros stay hidden until an enabled nonzero digit is seen.
    always_comb begin
        logic seen;
        seen = 1'b0;
        show = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            show[i] = active_nxt[i].on && ((i == 0) || seen || (active_nxt[i].val != 4'd0));
            if (active_nxt[i].on && (active_nxt[i].val != 4'd0)) begin
                seen = 1'b1;
            end
        end
    end
`else
    always_comb begin
        show = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            show[i] = active_nxt[i].on;
        end
    end
`endif

    // Outputs are decoded from next-state values so the registered pins line up with the slot counters.
    always_comb begin
        cur     = active_nxt[idx_nxt];
        seg_nxt = show[idx_nxt] ? {~cur.dp, font7(cur.val)} : 8'hFF;
        an_nxt  = '1;
        if ((div_nxt != '0) && show[idx_nxt]) begin
            an_nxt[idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            div_q       <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            seg_n       <= 8'hFF;
            an_n        <= '1;
            frame_start <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            run_q       <= 1'b1;
            div_q       <= div_nxt;
            idx_q       <= idx_nxt;
            seg_n       <= seg_nxt;
            an_n        <= an_nxt;
            frame_start <= (div_nxt == '0) && (idx_nxt == '0);
            if (commit_go) begin
                pending_q <= 1'b0;
            end else if (commit_req) begin
                pending_q <= 1'b1;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_q[i] <= active_nxt[i];
            end
            if (wr_hit) begin
                shadow_q[wr_addr[IW-1:0]] <= {wr_on, wr_dp, wr_data};
            end
        end
    end

endmodule
